// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer. Each channel has a 2-flop synchroniser, a bounce filter and a
// long-press timer, and produces a clean level plus press, release and long-press pulses.
module key_debounce_array #(
   parameter int unsigned CH         = 4,
   parameter int unsigned CNT_MAX    = 20,
   parameter int unsigned LONG_CNT   = 1000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] key,
   output logic [CH-1:0] key_level,
   output logic [CH-1:0] key_press,
   output logic [CH-1:0] key_release,
   output logic [CH-1:0] key_long
);

   localparam int unsigned BW = $clog2(CNT_MAX);
   localparam int unsigned HW = $clog2(LONG_CNT + 1);
   localparam logic [BW-1:0] BcntLast = BW'(CNT_MAX - 1);
   localparam logic [HW-1:0] HoldMax  = HW'(LONG_CNT);
   localparam logic [HW-1:0] HoldLast = HW'(LONG_CNT - 1);

   logic [CH-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [CH-1:0] level_q, level_d, press_q, press_d;
   logic [CH-1:0] release_q, release_d, long_q, long_d;
   logic [BW-1:0] bcnt_q [CH];
   logic [BW-1:0] bcnt_d [CH];
   logic [HW-1:0] hold_q [CH];
   logic [HW-1:0] hold_d [CH];

   always_comb begin
      s1_d      = ACTIVE_LOW ? ~key : key;
      s2_d      = s1_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      for (int i = 0; i < CH; i++) begin
         bcnt_d[i] = '0;
         hold_d[i] = hold_q[i];
         if (s2_q[i] != level_q[i]) begin
            if (bcnt_q[i] == BcntLast) begin
               level_d[i]   = s2_q[i];
               press_d[i]   = s2_q[i];
               release_d[i] = ~s2_q[i];
            end else begin
               bcnt_d[i] = bcnt_q[i] + 1'b1;
            end
         end
         // Clearing on the release edge too keeps key_long from coinciding with key_release.
         if (!level_d[i] || press_d[i]) begin
            hold_d[i] = '0;
         end else if (hold_q[i] != HoldMax) begin
            hold_d[i] = hold_q[i] + 1'b1;
            long_d[i] = (hold_q[i] == HoldLast);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int i = 0; i < CH; i++) begin
            bcnt_q[i] <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         for (int i = 0; i < CH; i++) begin
            bcnt_q[i] <= bcnt_d[i];
            hold_q[i] <= hold_d[i];
         end
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_long    = long_q;

endmodule
